// File: rtl/sprite_blitter.sv
// Sprite blitter: streams an image ROM in row-major order onto a
// clipped VGA pixel write port, with transparency and black-fill modes.
module sprite_blitter #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int SEL_W = 7,
  parameter logic [CW-1:0] TRANSP = 3'b101,
  localparam int AW =
    (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [XW-1:0]    xOrigin,
  input  logic [YW-1:0]    yOrigin,
  input  logic [SEL_W-1:0] imgSel,
  input  logic             black,
  input  logic             transpEn,
  output logic [AW-1:0]    romAddress,
  output logic [SEL_W-1:0] romSel,
  input  logic [CW-1:0]    romColor,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic [CW-1:0]    color,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  localparam int CXW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RYW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [AW-1:0] A_LAST =
    AW'(IMG_W * IMG_H - 1);
  localparam logic [CXW-1:0] C_LAST = CXW'(IMG_W - 1);
  localparam logic [XW:0] X_LIM = (XW + 1)'(SCR_W);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(SCR_H);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [XW-1:0]  xo_l;
  logic [YW-1:0]  yo_l;
  logic           blk_l;
  logic           tr_l;
  logic [CXW-1:0] col;
  logic [RYW-1:0] row;
  logic [CXW-1:0] col_d;
  logic [RYW-1:0] row_d;
  logic           pvalid;

  logic [XW:0] xs;
  logic [YW:0] ys;
  logic        hide;
  logic        accept;
  logic        last;

  assign accept = (state == IDLE) && start;
  assign last   = (romAddress == A_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = DRAW;
      DRAW:  if (last) nstate = FLUSH;
      FLUSH: nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xo_l       <= '0;
      yo_l       <= '0;
      blk_l      <= 1'b0;
      tr_l       <= 1'b0;
      romSel     <= '0;
      romAddress <= '0;
      col        <= '0;
      row        <= '0;
      col_d      <= '0;
      row_d      <= '0;
      pvalid     <= 1'b0;
    end else begin
      pvalid <= (state == DRAW);
      if (accept) begin
        xo_l       <= xOrigin;
        yo_l       <= yOrigin;
        blk_l      <= black;
        tr_l       <= transpEn;
        romSel     <= imgSel;
        romAddress <= '0;
        col        <= '0;
        row        <= '0;
      end else if (state == DRAW) begin
        col_d <= col;
        row_d <= row;
        // hold on the final pixel so no out-of-range address is issued
        if (!last) begin
          romAddress <= romAddress + AW'(1);
          if (col == C_LAST) begin
            col <= '0;
            row <= row + RYW'(1);
          end else begin
            col <= col + CXW'(1);
          end
        end
      end
    end
  end

  assign xs = {1'b0, xo_l} + (XW + 1)'(col_d);
  assign ys = {1'b0, yo_l} + (YW + 1)'(row_d);

  assign hide = tr_l && !blk_l && (romColor == TRANSP);

  always_comb begin
    x     = '0;
    y     = '0;
    color = '0;
    plot  = 1'b0;
    if (pvalid) begin
      x     = xs[XW-1:0];
      y     = ys[YW-1:0];
      color = blk_l ? '0 : romColor;
      plot  = (xs < X_LIM) && (ys < Y_LIM) && !hide;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
